// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the ALU arbiter slice: opcode and output-state
// encodings.
package alu_pkg;

    localparam int XLEN_DEF = 32;

    // Encodings 8..15 are unnamed and yield result 0, zero=1.
    typedef enum logic [3:0] {
        ALU_ADD = 4'd0,
        ALU_SUB = 4'd1,
        ALU_AND = 4'd2,
        ALU_OR  = 4'd3,
        ALU_XOR = 4'd4,
        ALU_SLL = 4'd5,
        ALU_SRL = 4'd6,
        ALU_SRA = 4'd7
    } alu_op_e;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } arb_state_e;

endpackage

// File: rtl/alu_arbiter_if.sv
// Request and response bundle between the two ALU requesters/consumer (master)
// and the arbiter (slave).
interface alu_arbiter_if
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
);
    logic [1:0]           req_valid;
    logic [1:0]           req_ready;
    logic [1:0][XLEN-1:0] req_a;
    logic [1:0][XLEN-1:0] req_b;
    logic [1:0][3:0]      req_op;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic                 rsp_id;
    logic [XLEN-1:0]      rsp_result;
    logic                 rsp_zero;

    modport master (
        output req_valid, req_a, req_b, req_op, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );

    modport slave (
        input  req_valid, req_a, req_b, req_op, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_result, rsp_zero
    );
endinterface

// File: rtl/alu_arbiter_alu.sv
// Combinational execute-stage ALU; shift amount is always b[4:0], and the
// unassigned opcodes produce zero.
module alu
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF
) (
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      alu_control,
    output logic [XLEN-1:0] result,
    output logic            zero
);
    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        result = '0;
        case (alu_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_XOR: result = a ^ b;
            ALU_SLL: result = a << shamt;
            ALU_SRL: result = a >> shamt;
            ALU_SRA: result = $signed(a) >>> shamt;
            default: result = '0;
        endcase
    end

    assign zero = (result == '0);
endmodule

// File: rtl/alu_arbiter.sv
// Shares one ALU between two requesters and returns results through a one-entry
// response register. Define ALU_ARB_RR_EN for round-robin; otherwise requester 0
// has fixed priority.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int XLEN = XLEN_DEF,
    parameter int NREQ = 2
) (
    input  logic         clk,
    input  logic         rst,
    alu_arbiter_if.slave bus
);
    arb_state_e      state_q, state_d;
    logic            rsp_id_q, rsp_id_d;
    logic [XLEN-1:0] rsp_result_q, rsp_result_d;
    logic            rsp_zero_q, rsp_zero_d;

    logic            grant_ok;
    logic            grant;
    logic            winner;
    logic [XLEN-1:0] alu_a, alu_b, alu_result;
    logic [3:0]      alu_op;
    logic            alu_zero;

`ifdef ALU_ARB_RR_EN
    logic last_q, last_d;
`endif

    // The winner depends only on valids and the pointer, never on operand data.
    always_comb begin
        grant_ok = !rst && ((state_q == EMPTY) || bus.rsp_ready);
        grant    = grant_ok && (|bus.req_valid);
        winner   = bus.req_valid[1];
        if (&bus.req_valid) begin
`ifdef ALU_ARB_RR_EN
            winner = ~last_q;
`else
            winner = 1'b0;
`endif
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < NREQ; gi++) begin : g_ready
            assign bus.req_ready[gi] = grant && (winner == 1'(gi));
        end
    endgenerate

    assign alu_a  = bus.req_a[winner];
    assign alu_b  = bus.req_b[winner];
    assign alu_op = bus.req_op[winner];

    alu #(.XLEN(XLEN)) u_alu (
        .a           (alu_a),
        .b           (alu_b),
        .alu_control (alu_op),
        .result      (alu_result),
        .zero        (alu_zero)
    );

    always_comb begin
        state_d      = state_q;
        rsp_id_d     = rsp_id_q;
        rsp_result_d = rsp_result_q;
        rsp_zero_d   = rsp_zero_q;
        if (grant) begin
            state_d      = FULL;
            rsp_id_d     = winner;
            rsp_result_d = alu_result;
            rsp_zero_d   = alu_zero;
        end else if ((state_q == FULL) && bus.rsp_ready) begin
            state_d = EMPTY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= EMPTY;
            rsp_id_q     <= 1'b0;
            rsp_result_q <= '0;
            rsp_zero_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rsp_id_q     <= rsp_id_d;
            rsp_result_q <= rsp_result_d;
            rsp_zero_q   <= rsp_zero_d;
        end
    end

`ifdef ALU_ARB_RR_EN
    // Pointer follows every grant, contested or not.
    always_comb begin
        last_d = last_q;
        if (grant) begin
            last_d = winner;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    assign bus.rsp_valid  = (state_q == FULL);
    assign bus.rsp_id     = rsp_id_q;
    assign bus.rsp_result = rsp_result_q;
    assign bus.rsp_zero   = rsp_zero_q;
endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios followed by random
// traffic, all compared against a cycle-level behavioural model.
module tb_alu_arbiter;
    import alu_pkg::*;

`ifdef ALU_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_arbiter_if #(.XLEN(32)) bus ();

    alu_arbiter #(.XLEN(32), .NREQ(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Behavioural model of the response register and arbitration pointer
    bit          m_full;
    bit          m_id;
    logic [31:0] m_res;
    bit          m_zero;
    int          m_last;
    logic [1:0]  exp_g;
    logic [1:0]  obs_rdy;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] alu_ref(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
        int sh;
        sh = int'(b[4:0]);
        case (op)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return a << sh;
            4'd6: return a >> sh;
            4'd7: return a[31] ? ~((~a) >> sh) : (a >> sh);
            default: return 32'd0;
        endcase
    endfunction

    task automatic model_reset();
        m_full = 1'b0;
        m_id   = 1'b0;
        m_res  = 32'd0;
        m_zero = 1'b0;
        m_last = 1;
    endtask

    // One clock: check outputs at the falling edge, then advance the model.
    task automatic cycle();
        bit g;
        int w;
        @(negedge clk);
        g = !rst && (!m_full || bus.rsp_ready) && (bus.req_valid != 2'b00);
        if (bus.req_valid == 2'b11) w = RR ? (1 - m_last) : 0;
        else                        w = bus.req_valid[1] ? 1 : 0;
        exp_g = 2'b00;
        if (g) exp_g[w] = 1'b1;
        obs_rdy = bus.req_ready;
        check("req_ready", obs_rdy, exp_g);
        check("rsp_valid", bus.rsp_valid, m_full);
        check("rsp_id", bus.rsp_id, m_id);
        check("rsp_result", bus.rsp_result, m_res);
        check("rsp_zero", bus.rsp_zero, m_zero);
        @(posedge clk);
        #1;
        if (rst) begin
            model_reset();
        end else if (g) begin
            m_full = 1'b1;
            m_id   = (w == 1);
            m_res  = alu_ref(bus.req_op[w], bus.req_a[w], bus.req_b[w]);
            m_zero = (m_res == 32'd0);
            m_last = w;
            $display("grant req%0d op=%0d a=%08h b=%08h result=%08h", w, bus.req_op[w],
                     bus.req_a[w], bus.req_b[w], m_res);
        end else if (m_full && bus.rsp_ready) begin
            m_full = 1'b0;
        end
    endtask

    task automatic set_req(input int i, input logic [3:0] op, input logic [31:0] a,
                           input logic [31:0] b);
        bus.req_valid[i] = 1'b1;
        bus.req_op[i]    = op;
        bus.req_a[i]     = a;
        bus.req_b[i]     = b;
    endtask

    task automatic new_rand_req(input int i);
        logic [31:0] a;
        a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom;
        set_req(i, 4'($urandom_range(0, 15)), a, $urandom);
    endtask

    initial begin
        logic [31:0] held;
        rst           = 1'b1;
        bus.req_valid = 2'b00;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_op    = '0;
        bus.rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        cycle();

        // Single request
        rst = 1'b0;
        bus.rsp_ready = 1'b1;
        set_req(0, ALU_ADD, 32'd5, 32'd7);
        cycle();
        bus.req_valid = 2'b00;
        check("single_grant", obs_rdy, 2'b01);
        check("single_valid", bus.rsp_valid, 1'b1);
        check("single_id", bus.rsp_id, 1'b0);
        check("single_result", bus.rsp_result, 32'd12);
        check("single_zero", bus.rsp_zero, 1'b0);
        cycle();

        // Conflict: both held valid for four cycles from a fresh pointer
        rst = 1'b1;
        cycle();
        rst = 1'b0;
        set_req(0, ALU_SUB, 32'd9, 32'd9);
        set_req(1, ALU_SRA, 32'h8000_0000, 32'd4);
        for (int k = 0; k < 4; k++) begin
            bit w1;
            cycle();
            w1 = RR && (k % 2 == 1);
            check("conflict_grant", obs_rdy, w1 ? 2'b10 : 2'b01);
            check("conflict_result", bus.rsp_result, w1 ? 32'hF800_0000 : 32'd0);
            check("conflict_zero", bus.rsp_zero, w1 ? 1'b0 : 1'b1);
        end
        bus.req_valid = 2'b00;
        cycle();

        // Backpressure, then simultaneous drain and grant
        set_req(1, ALU_XOR, 32'hFF, 32'h0F);
        cycle();
        bus.req_valid = 2'b00;
        set_req(0, ALU_OR, 32'd1, 32'd2);
        bus.rsp_ready = 1'b0;
        held = bus.rsp_result;
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("bp_ready", obs_rdy, 2'b00);
            check("bp_hold", bus.rsp_result, 32'hF0);
            check("bp_hold_match", bus.rsp_result, held);
        end
        bus.rsp_ready = 1'b1;
        cycle();
        check("bp_drain_grant", obs_rdy, 2'b01);
        check("bp_new_result", bus.rsp_result, 32'd3);
        bus.req_valid = 2'b00;
        cycle();

        // Shift amount and unused opcode
        set_req(0, ALU_SLL, 32'd1, 32'h21);
        cycle();
        check("sll_mask", bus.rsp_result, 32'd2);
        set_req(0, 4'd13, 32'hDEAD, 32'hBEEF);
        cycle();
        check("op13_result", bus.rsp_result, 32'd0);
        check("op13_zero", bus.rsp_zero, 1'b1);
        bus.req_valid = 2'b00;
        cycle();

        // Streaming from requester 1
        for (int k = 0; k < 8; k++) begin
            set_req(1, ALU_ADD, 32'(k), 32'd100);
            cycle();
            check("stream_grant", obs_rdy, 2'b10);
            check("stream_valid", bus.rsp_valid, 1'b1);
            check("stream_result", bus.rsp_result, 32'(k + 100));
        end
        bus.req_valid = 2'b00;
        cycle();

        // Reset while holding an unconsumed response
        set_req(0, ALU_ADD, 32'h1234, 32'd0);
        cycle();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 1'b0;
        cycle();
        rst = 1'b1;
        set_req(1, ALU_ADD, 32'd1, 32'd1);
        cycle();
        check("rst_no_grant", obs_rdy, 2'b00);
        rst = 1'b0;
        bus.req_valid = 2'b00;
        check("rst_valid", bus.rsp_valid, 1'b0);
        check("rst_result", bus.rsp_result, 32'd0);
        bus.rsp_ready = 1'b1;
        repeat (2) cycle();

        // Random traffic honouring the requester obligations
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < 2; i++) begin
                if (exp_g[i] || !bus.req_valid[i] || rst) begin
                    if ($urandom_range(0, 3) != 0) new_rand_req(i);
                    else bus.req_valid[i] = 1'b0;
                end
            end
            bus.rsp_ready = ($urandom_range(0, 9) < 7);
            rst = ($urandom_range(0, 49) == 0);
            cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Round-robin arbiter and sequencer that shares the single execute-stage `alu` between two requesters: requester 0 is the execute pipeline and requester 1 is the address/branch-compare unit. Each request is a valid/ready transaction carrying operands and a 4-bit ALU opcode. The winning request drives the `alu` combinationally, and its result and zero flag are captured in a one-entry output register. The registered result is returned on a tagged response channel with backpressure.

## Interface
Parameters:
- `XLEN`, 32, operand/result width
- `NREQ`, 2, number of requesters; fixed at 2 in this revision

Ports:
- `clk` input 1: clock, rising edge
- `rst` input 1: synchronous, active-high reset
- `req_valid` input [1:0]: request valid, per requester
- `req_ready` output [1:0]: request accepted this cycle, per requester
- `req_a` input [1:0][XLEN-1:0]: operand A, per requester
- `req_b` input [1:0][XLEN-1:0]: operand B, per requester
- `req_op` input [1:0][3:0]: ALU opcode (`alu_op_e`), per requester
- `rsp_valid` output 1: response register holds a result
- `rsp_ready` input 1: consumer accepts the response
- `rsp_id` output 1: index of the requester that produced the response
- `rsp_result` output XLEN: ALU result
- `rsp_zero` output 1: result == 0

## Operation
- Opcode encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR
  - 5 SLL, 6 SRL, 7 SRA; shift amount is `b[4:0]`
  - 8–15: result 0, zero=1, accepted normally (no error signalled)
- Arithmetic is modulo 2^XLEN; SRA sign-extends from bit XLEN-1.
- Output state machine:
  - EMPTY: `rsp_valid`=0.
  - FULL: `rsp_valid`=1.
  - EMPTY→FULL on a grant.
  - FULL→EMPTY on `rsp_ready` with no grant.
  - FULL→FULL on `rsp_ready` with a grant (back-to-back).
  - FULL with `rsp_ready`=0: no grant, all outputs held stable.
- Grant is allowed when the state is EMPTY, or FULL with `rsp_ready`=1.
- Arbitration:
  - One requester valid: it wins.
  - Both valid: winner chosen by policy (see Configuration).
- `req_ready[i]` is 1 only for the winner in a grant-allowed cycle.
- `req_ready` depends combinationally on `req_valid` and `rsp_ready`. No combinational path from `req_a`, `req_b` or `req_op` to `req_ready`.
- On grant, the following are registered from the `alu` outputs for the winning operands: `rsp_id`=winner, `rsp_result`, `rsp_zero`.
- Requester obligations:
  - Once `req_valid` is raised, hold `req_a`, `req_b` and `req_op` stable until `req_ready`.
  - Do not drop `req_valid` before `req_ready`.
- Response data is held stable while `rsp_valid` && !`rsp_ready`.

## Timing
- Latency: request accepted at edge N → `rsp_valid` visible after edge N.
- Throughput: one operation per cycle when `rsp_ready` is held high.
- Reset values: `rsp_valid`=0, `rsp_id`=0, `rsp_result`=0, `rsp_zero`=0, `req_ready`=0, round-robin pointer `last`=1, state EMPTY.
- Reset asserted mid-transaction: the held response is discarded and no grant occurs in the reset cycle. The requester re-presents its request after reset.
- Simultaneous drain and new grant in the same cycle: the new result replaces the old one at the edge, with no bubble.
- `rsp_ready`=1 while EMPTY: no effect.

## Configuration
- `ALU_ARB_RR_EN` defined:
  - Round-robin. When both requesters are valid, the grant goes to the requester not equal to `last`.
  - `last` updates to the winner on every grant, including uncontested grants.
- `ALU_ARB_RR_EN` undefined:
  - Fixed priority; requester 0 always wins conflicts.
  - The `last` register is removed.
  - Reset and all other behaviour are identical.

## Structure
- `alu_pkg` holds:
  - `alu_op_e` (4-bit enum, encodings above)
  - `arb_state_e` {EMPTY, FULL}
  - `XLEN_DEF` = 32
- One sub-module: the existing combinational `alu` (a, b, alu_control → result, zero), instantiated once and fed through the grant mux.
- Arbiter, mux and response register stay in `alu_arbiter`.

## Test plan
- Single request: req0 ADD a=5, b=7, `rsp_ready`=1 → `req_ready[0]`=1 in the same cycle; next cycle `rsp_valid`=1, `rsp_id`=0, `rsp_result`=12, `rsp_zero`=0.
- Conflict with RR enabled, both requesters held valid for 4 cycles:
  - req0 SUB 9−9; req1 SRA a=0x8000_0000, b=4.
  - Grants go 0, 1, 0, 1.
  - Responses: result 0 with zero=1; then 0xF800_0000 with zero=0.
  - With the macro undefined, all 4 grants go to requester 0.
- Backpressure:
  - `rsp_ready`=0 for 3 cycles while FULL → `req_ready`=00 and response outputs stable.
  - `rsp_ready` raised → drain and new grant in the same cycle.
- Shift amount and opcode edges:
  - SLL a=1, b=0x21 → result 2, since only `b[4:0]` is used.
  - op=13 → result 0, zero=1.
- Streaming: 8 back-to-back requests from requester 1 with `rsp_ready`=1 → 8 responses on 8 consecutive cycles, with no bubble.
- Reset mid-operation: assert `rst` while FULL and `rsp_ready`=0 → next cycle `rsp_valid`=0, and the held result is never emitted.
